// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: SPI pins, memory preload port and command status of the flash stand-in
//   slave  : device side (SPI/load inputs in, MISO and status out)
//   master : initiator/bench side
interface spi_flash_responder_if #(parameter int ADDR_BITS = 8);
  logic                 iSPIClock;
  logic                 iSPICs;
  logic                 iSPIIn;
  logic                 oSPIOut;
  logic                 iLoadEnable;
  logic [ADDR_BITS-1:0] iLoadAddress;
  logic [7:0]           iLoadData;
  logic                 oBusy;
  logic                 oCmdValid;
  logic [23:0]          oAddress;
  modport slave (
    input  iSPIClock, iSPICs, iSPIIn, iLoadEnable, iLoadAddress, iLoadData,
    output oSPIOut, oBusy, oCmdValid, oAddress
  );
  modport master (
    output iSPIClock, iSPICs, iSPIIn, iLoadEnable, iLoadAddress, iLoadData,
    input  oSPIOut, oBusy, oCmdValid, oAddress
  );
endinterface

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: serial flash READ responder (mode 0) serving a preloadable byte memory
//   Clock, Reset : system clock, synchronous active-high reset
//   bus (slave)  : SCK/CS/MOSI in, MISO out, memory load port, busy/cmd-valid/address status
module spi_flash_responder #(
  parameter int         ADDR_BITS    = 8,
  parameter logic [7:0] SPI_CMD_READ = 8'h03
) (
  input logic Clock,
  input logic Reset,
  spi_flash_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
  state_t               state_q, state_d;
  logic [2:0]           sck_q, cs_q, mosi_q;
  logic [5:0]           cnt_q, cnt_d;
  logic [22:0]          shift_q, shift_d;
  logic [23:0]          shin, oaddr_q, oaddr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d, rd_addr;
  logic [2:0]           bit_q, bit_d;
  logic                 miso_q, miso_d, valid_q, valid_d, rd_en;
  logic                 sck_rise, sck_fall, cs_fall, cs_rise;
  logic [7:0]           mem [2**ADDR_BITS];
  logic [7:0]           rdata_q;
  // Bit 1 is the synchronized value, bit 2 the history used for edge detection.
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign shin     = {shift_q, mosi_q[2]};
  assign bus.oSPIOut   = miso_q;
  assign bus.oCmdValid = valid_q;
  assign bus.oAddress  = oaddr_q;
  // IGNORE still owns the selected link, so it reports busy until CS rises.
  assign bus.oBusy     = state_q != IDLE;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      // Synchronizers clear to 0, so a CS already low at release never looks like a fall.
      sck_q   <= '0;
      cs_q    <= '0;
      mosi_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      oaddr_q <= '0;
      addr_q  <= '0;
      bit_q   <= '0;
      miso_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sck_q   <= {sck_q[1:0], bus.iSPIClock};
      cs_q    <= {cs_q[1:0], bus.iSPICs};
      mosi_q  <= {mosi_q[1:0], bus.iSPIIn};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      oaddr_q <= oaddr_d;
      addr_q  <= addr_d;
      bit_q   <= bit_d;
      miso_q  <= miso_d;
      valid_q <= valid_d;
    end
  end
  // Read-before-write: a same-cycle read of the written location returns old data.
  always_ff @(posedge Clock) begin
    if (bus.iLoadEnable) mem[bus.iLoadAddress] <= bus.iLoadData;
    if (rd_en) rdata_q <= mem[rd_addr];
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    oaddr_d = oaddr_q;
    addr_d  = addr_q;
    bit_d   = bit_q;
    miso_d  = miso_q;
    valid_d = 1'b0;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    if (cs_rise) begin
      state_d = IDLE;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d  = 1'b0;
          state_d = cs_fall ? CMD : IDLE;
          cnt_d   = cs_fall ? 6'd0 : cnt_q;
        end
        CMD: if (sck_rise) begin
          shift_d = shin[22:0];
          cnt_d   = cnt_q == 6'd7 ? 6'd0 : cnt_q + 6'd1;
          if (cnt_q == 6'd7) state_d = shin[7:0] == SPI_CMD_READ ? ADDR : IGNORE;
        end
        ADDR: if (sck_rise) begin
          shift_d = shin[22:0];
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == 6'd23) begin
            oaddr_d = shin;
            valid_d = 1'b1;
            addr_d  = shin[ADDR_BITS-1:0];
            rd_en   = 1'b1;
            rd_addr = shin[ADDR_BITS-1:0];
            bit_d   = 3'd7;
            state_d = DATA;
          end
        end
        DATA: if (sck_fall) begin
          miso_d = rdata_q[bit_q];
          bit_d  = bit_q - 3'd1;
          // Driving bit 0 prefetches the next byte; it lands long before the next fall.
          if (bit_q == 3'd0) begin
            addr_d  = addr_q + ADDR_BITS'(1);
            rd_en   = 1'b1;
            rd_addr = addr_q + ADDR_BITS'(1);
          end
        end
        default: miso_d = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed table-driven bench for spi_flash_responder
module tb_spi_flash_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   vcnt = 0;
  always #5 clk = ~clk;
  spi_flash_responder_if #(.ADDR_BITS(8)) bus();
  spi_flash_responder #(.ADDR_BITS(8), .SPI_CMD_READ(8'h03)) dut (
    .Clock(clk),
    .Reset(rst),
    .bus(bus)
  );
  always @(posedge clk) if (bus.oCmdValid === 1'b1) vcnt++;
  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [15:0] exp_d;
    int          exp_v;
    logic [23:0] exp_a;
  } vec_t;
  vec_t tv[4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic sbit(input logic b, output logic m);
    bus.iSPIIn = b;
    wclk(5);
    m = bus.oSPIOut;
    bus.iSPIClock = 1'b1;
    wclk(5);
    bus.iSPIClock = 1'b0;
  endtask
  task automatic sendv(input logic [31:0] v, input int n);
    logic m;
    for (int i = n - 1; i >= 0; i--) sbit(v[i], m);
  endtask
  task automatic readv(input int n, output logic [15:0] d);
    logic m;
    d = '0;
    for (int i = 0; i < n; i++) begin
      sbit(1'b0, m);
      d = {d[14:0], m};
    end
  endtask
  task automatic csdown();
    bus.iSPICs = 1'b0;
    wclk(5);
  endtask
  task automatic csup();
    wclk(2);
    bus.iSPICs = 1'b1;
    wclk(8);
  endtask
  task automatic load(input logic [7:0] a, input logic [7:0] d);
    bus.iLoadEnable  = 1'b1;
    bus.iLoadAddress = a;
    bus.iLoadData    = d;
    wclk(1);
    bus.iLoadEnable  = 1'b0;
  endtask
  initial begin
    logic [15:0] d;
    int v0;
    tv[0] = '{8'h03, 24'h000010, 8'hA5, 8'h3C, 16'hA53C, 1, 24'h000010};
    tv[1] = '{8'h03, 24'hABCDFF, 8'h81, 8'h7E, 16'h817E, 1, 24'hABCDFF};
    tv[2] = '{8'h0B, 24'h001234, 8'hFF, 8'hFF, 16'h0000, 0, 24'hABCDFF};
    tv[3] = '{8'h03, 24'h000042, 8'h00, 8'hFF, 16'h00FF, 1, 24'h000042};
    bus.iSPIClock = 1'b0;
    bus.iSPICs = 1'b1;
    bus.iSPIIn = 1'b0;
    bus.iLoadEnable = 1'b0;
    bus.iLoadAddress = '0;
    bus.iLoadData = '0;
    wclk(4);
    rst = 1'b0;
    wclk(8);
    chk("reset_miso", 32'(bus.oSPIOut), 32'd0);
    chk("reset_busy", 32'(bus.oBusy), 32'd0);
    chk("reset_valid", 32'(bus.oCmdValid), 32'd0);
    chk("reset_addr", 32'(bus.oAddress), 32'd0);
    for (int i = 0; i < 4; i++) begin
      load(tv[i].addr[7:0], tv[i].d0);
      load(tv[i].addr[7:0] + 8'd1, tv[i].d1);
      v0 = vcnt;
      csdown();
      sendv({tv[i].cmd, tv[i].addr}, 32);
      readv(16, d);
      chk($sformatf("v%0d_busy_sel", i), 32'(bus.oBusy), 32'd1);
      csup();
      chk($sformatf("v%0d_miso", i), 32'(d), 32'(tv[i].exp_d));
      chk($sformatf("v%0d_valid_cnt", i), 32'(vcnt - v0), 32'(tv[i].exp_v));
      chk($sformatf("v%0d_addr", i), 32'(bus.oAddress), 32'(tv[i].exp_a));
      chk($sformatf("v%0d_busy_idle", i), 32'(bus.oBusy), 32'd0);
    end
    load(8'h05, 8'hF0);
    load(8'h06, 8'h11);
    v0 = vcnt;
    csdown();
    sendv({8'h03, 24'h000005}, 20);
    csup();
    chk("abort_busy", 32'(bus.oBusy), 32'd0);
    chk("abort_valid", 32'(vcnt - v0), 32'd0);
    csdown();
    sendv({8'h03, 24'h000005}, 32);
    readv(16, d);
    csup();
    chk("abort_retry_miso", 32'(d), 32'h0000F011);
    chk("abort_retry_valid", 32'(vcnt - v0), 32'd1);
    chk("abort_retry_addr", 32'(bus.oAddress), 32'h000005);
    load(8'h30, 8'hC3);
    load(8'h31, 8'h5A);
    csdown();
    sendv({8'h03, 24'h000030}, 32);
    readv(1, d);
    wclk(5);
    chk("rst_pre_bit", 32'(d), 32'd1);
    chk("rst_pre_miso", 32'(bus.oSPIOut), 32'd1);
    v0 = vcnt;
    rst = 1'b1;
    wclk(1);
    rst = 1'b0;
    chk("rst_miso", 32'(bus.oSPIOut), 32'd0);
    chk("rst_busy", 32'(bus.oBusy), 32'd0);
    sendv({8'h03, 24'h000030}, 32);
    readv(8, d);
    chk("rst_ignored_miso", 32'(d), 32'd0);
    chk("rst_ignored_busy", 32'(bus.oBusy), 32'd0);
    chk("rst_ignored_valid", 32'(vcnt - v0), 32'd0);
    csup();
    csdown();
    sendv({8'h03, 24'h000030}, 32);
    readv(16, d);
    csup();
    chk("rst_after_miso", 32'(d), 32'h0000C35A);
    chk("rst_after_valid", 32'(vcnt - v0), 32'd1);
    load(8'h20, 8'h11);
    load(8'h21, 8'h22);
    csdown();
    sendv({8'h03, 24'h000020}, 32);
    readv(2, d);
    load(8'h21, 8'h55);
    begin
      logic [15:0] r;
      readv(14, r);
      d = {d[1:0], r[13:0]};
    end
    csup();
    chk("load_stream_miso", 32'(d), 32'h00001155);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
